// File: rtl/uart_receiver_if.sv
// Serial receive port bundle: line and oversampling tick in, character and status out.
interface uart_receiver_if #(
   parameter int DATA_BITS = 7
);
   logic                 i_rx;
   logic                 i_rx_en;
   logic [DATA_BITS-1:0] o_data_out;
   logic                 o_data_valid;
   logic                 o_parity_error;
   logic                 o_framing_error;
   logic                 o_busy;

   // Side that drives the serial line and consumes received characters.
   modport master (
      output i_rx, i_rx_en,
      input  o_data_out, o_data_valid, o_parity_error, o_framing_error, o_busy
   );

   // The receiver itself.
   modport slave (
      input  i_rx, i_rx_en,
      output o_data_out, o_data_valid, o_parity_error, o_framing_error, o_busy
   );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, odd parity, one stop bit.
// The line is sampled at mid-bit using OVERSAMPLE rx_en ticks per bit period.
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 7
) (
   input  logic            clk,
   input  logic            resetN,
   uart_receiver_if.slave  bus
);
   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);
   localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic                 r_sync1, r_rx_s, r_rx_prev;
   state_t               r_state, w_state_next;
   logic [TICK_W-1:0]    r_tick, w_tick_next;
   logic [BIT_W-1:0]     r_bit, w_bit_next;
   logic [DATA_BITS-1:0] r_shift, w_shift_next;
   logic                 r_par, w_par_next;
   logic [DATA_BITS-1:0] r_data_out, w_data_out_next;
   logic                 r_data_valid, w_data_valid_next;
   logic                 r_parity_error, w_parity_error_next;
   logic                 r_framing_error, w_framing_error_next;

   // Two-flop synchroniser on the line; rx_prev remembers the line as seen on the last tick.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1 <= bus.i_rx;
         r_rx_s  <= r_sync1;
         if (bus.i_rx_en)
            r_rx_prev <= r_rx_s;
      end
   end

   // Frame state, counters and output registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state         <= S_IDLE;
         r_tick          <= '0;
         r_bit           <= '0;
         r_shift         <= '0;
         r_par           <= 1'b0;
         r_data_out      <= '0;
         r_data_valid    <= 1'b0;
         r_parity_error  <= 1'b0;
         r_framing_error <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_tick          <= w_tick_next;
         r_bit           <= w_bit_next;
         r_shift         <= w_shift_next;
         r_par           <= w_par_next;
         r_data_out      <= w_data_out_next;
         r_data_valid    <= w_data_valid_next;
         r_parity_error  <= w_parity_error_next;
         r_framing_error <= w_framing_error_next;
      end
   end

   // Next-state logic; everything advances only on rx_en ticks, data_valid self-clears.
   always_comb begin
      w_state_next         = r_state;
      w_tick_next          = r_tick;
      w_bit_next           = r_bit;
      w_shift_next         = r_shift;
      w_par_next           = r_par;
      w_data_out_next      = r_data_out;
      w_data_valid_next    = 1'b0;
      w_parity_error_next  = r_parity_error;
      w_framing_error_next = r_framing_error;
      if (bus.i_rx_en) begin
         case (r_state)
            S_IDLE: begin
               // Only a high-to-low transition starts a frame; a held-low line does not.
               if (r_rx_prev && !r_rx_s) begin
                  w_state_next = S_START;
                  w_tick_next  = '0;
               end
            end
            S_START: begin
               if (r_tick == HALF_LAST) begin
                  w_tick_next = '0;
                  if (!r_rx_s) begin
                     w_state_next = S_DATA;
                     w_bit_next   = '0;
                  end else begin
                     w_state_next = S_IDLE;   // glitch shorter than half a bit
                  end
               end else begin
                  w_tick_next = r_tick + TICK_W'(1);
               end
            end
            S_DATA: begin
               if (r_tick == FULL_LAST) begin
                  w_tick_next         = '0;
                  w_shift_next[r_bit] = r_rx_s;
                  if (r_bit == BIT_LAST)
                     w_state_next = S_PARITY;
                  else
                     w_bit_next = r_bit + BIT_W'(1);
               end else begin
                  w_tick_next = r_tick + TICK_W'(1);
               end
            end
            S_PARITY: begin
               if (r_tick == FULL_LAST) begin
                  w_tick_next  = '0;
                  w_par_next   = r_rx_s;
                  w_state_next = S_STOP;
               end else begin
                  w_tick_next = r_tick + TICK_W'(1);
               end
            end
            S_STOP: begin
               // Returning to idle at mid-stop lets a back-to-back start edge be caught.
               if (r_tick == FULL_LAST) begin
                  w_tick_next          = '0;
                  w_data_out_next      = r_shift;
                  w_parity_error_next  = (r_par != ~^r_shift);
                  w_framing_error_next = ~r_rx_s;
                  w_data_valid_next    = 1'b1;
                  w_state_next         = S_IDLE;
               end else begin
                  w_tick_next = r_tick + TICK_W'(1);
               end
            end
            default: begin
               w_state_next = S_IDLE;
               w_tick_next  = '0;
            end
         endcase
      end
   end

   assign bus.o_data_out      = r_data_out;
   assign bus.o_data_valid    = r_data_valid;
   assign bus.o_parity_error  = r_parity_error;
   assign bus.o_framing_error = r_framing_error;
   assign bus.o_busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of directed frames, hand-written
// corner sequences, and random frames checked against a frame-level model.
module tb_uart_receiver;
   localparam int OS  = 16;
   localparam int DIV = 4;                       // clk cycles per rx_en tick
   // Edge launched just after a tick is first seen on the next tick, then
   // (DATA_BITS+2)*OS + OS/2 ticks to the mid-stop sampling tick.
   localparam int LAT = (7 + 2) * OS + OS / 2 + 1;

   logic clk;
   logic resetN;

   uart_receiver_if #(.DATA_BITS(7)) bus ();

   uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(7)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   typedef struct {
      logic [6:0] d;
      logic       p;
      logic       s;
      logic [6:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
      int         hold;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int tick_cnt = 0;
   int dv_cnt   = 0;
   int rd_idx   = 0;
   int busy_clks = 0;
   int width_bad = 0;
   int busy_bad  = 0;
   logic dv_prev = 1'b0;
   logic [6:0] cap_data [0:63];
   logic       cap_pe   [0:63];
   logic       cap_fe   [0:63];
   int         cap_tick [0:63];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // rx_en: one-clk pulse every DIV clocks, changed on the falling edge.
   initial begin
      bus.i_rx_en = 1'b0;
      forever begin
         repeat (DIV - 1) @(negedge clk);
         bus.i_rx_en = 1'b1;
         @(negedge clk);
         bus.i_rx_en = 1'b0;
      end
   end

   // Tick counter used for latency measurements.
   always @(posedge clk)
      if (bus.i_rx_en) tick_cnt <= tick_cnt + 1;

   // Output monitor: capture each delivered character and note pulse-shape problems.
   always @(negedge clk) begin
      if (bus.o_busy) busy_clks <= busy_clks + 1;
      if (bus.o_data_valid) begin
         if (dv_prev) width_bad <= width_bad + 1;
         if (bus.o_busy) busy_bad <= busy_bad + 1;
         if (dv_cnt < 64) begin
            cap_data[dv_cnt] <= bus.o_data_out;
            cap_pe[dv_cnt]   <= bus.o_parity_error;
            cap_fe[dv_cnt]   <= bus.o_framing_error;
            cap_tick[dv_cnt] <= tick_cnt;
         end
         dv_cnt <= dv_cnt + 1;
      end
      dv_prev <= bus.o_data_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (bus.i_rx_en !== 1'b1);
      #1;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) wait_tick();
   endtask

   task automatic drive_bit(input logic v);
      bus.i_rx = v;
      wait_ticks(OS);
   endtask

   task automatic send_frame(input logic [6:0] d, input logic p, input logic s, output int st);
      st = tick_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 7; i++) drive_bit(d[i]);
      drive_bit(p);
      drive_bit(s);
   endtask

   task automatic check_frame(input string tag, input logic [6:0] d, input logic pe,
                              input logic fe, input int st);
      check({tag, "_dv_count"}, dv_cnt - rd_idx, 1);
      if (dv_cnt > rd_idx) begin
         check({tag, "_data"},    cap_data[rd_idx], d);
         check({tag, "_parity"},  cap_pe[rd_idx], pe);
         check({tag, "_framing"}, cap_fe[rd_idx], fe);
         check({tag, "_latency"}, cap_tick[rd_idx] - st, LAT);
         $display("%s: data_out=%02h parity_error=%0d framing_error=%0d (expected %02h %0d %0d)",
                  tag, cap_data[rd_idx], cap_pe[rd_idx], cap_fe[rd_idx], d, pe, fe);
         rd_idx = dv_cnt;
      end
      check({tag, "_dv_width"}, width_bad, 0);
      check({tag, "_busy_at_dv"}, busy_bad, 0);
   endtask

   initial begin
      vec_t vecs [4];
      int st, st0, n0, b0;
      logic [6:0] rd;
      logic rp, rs, exp_pe;

      // data, parity, stop, expected data, parity_error, framing_error, low-hold ticks
      vecs[0] = '{7'h55, 1'b1, 1'b1, 7'h55, 1'b0, 1'b0, 0};
      vecs[1] = '{7'h7F, 1'b1, 1'b1, 7'h7F, 1'b1, 1'b0, 0};
      vecs[2] = '{7'h00, 1'b1, 1'b1, 7'h00, 1'b0, 1'b0, 0};
      vecs[3] = '{7'h2A, 1'b0, 1'b0, 7'h2A, 1'b0, 1'b1, 3 * OS};

      bus.i_rx = 1'b1;
      resetN   = 1'b0;
      #15;
      check("reset_data_out",  bus.o_data_out, 0);
      check("reset_dv",        bus.o_data_valid, 0);
      check("reset_parity",    bus.o_parity_error, 0);
      check("reset_framing",   bus.o_framing_error, 0);
      check("reset_busy",      bus.o_busy, 0);
      $display("reset: outputs idle");
      @(negedge clk);
      resetN = 1'b1;
      wait_ticks(8);

      // Directed frames.
      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].d, vecs[i].p, vecs[i].s, st);
         check_frame($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe, st);
         if (vecs[i].hold > 0) begin
            bus.i_rx = vecs[i].s;
            b0 = busy_clks;
            n0 = dv_cnt;
            wait_ticks(vecs[i].hold);
            check($sformatf("vec%0d_hold_busy", i), busy_clks - b0, 0);
            check($sformatf("vec%0d_hold_dv", i), dv_cnt - n0, 0);
         end
         bus.i_rx = 1'b1;
         wait_ticks(4);
      end

      // Short glitch: rejected at mid start bit.
      b0 = busy_clks;
      n0 = dv_cnt;
      bus.i_rx = 1'b0;
      wait_ticks(4);
      bus.i_rx = 1'b1;
      wait_ticks(OS);
      check("glitch_busy_clks", busy_clks - b0, (OS / 2) * DIV);
      check("glitch_dv", dv_cnt - n0, 0);
      check("glitch_data_hold", bus.o_data_out, 7'h2A);
      check("glitch_fe_hold", bus.o_framing_error, 1);
      $display("glitch: busy for %0d clk, no character", busy_clks - b0);

      // Reset during data bit 3 abandons the frame.
      n0 = dv_cnt;
      rd = 7'h41;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(rd[i]);
      bus.i_rx = rd[3];
      wait_ticks(OS / 2);
      #3;
      resetN = 1'b0;
      #1;
      check("midreset_data_out", bus.o_data_out, 0);
      check("midreset_framing",  bus.o_framing_error, 0);
      check("midreset_parity",   bus.o_parity_error, 0);
      check("midreset_busy",     bus.o_busy, 0);
      bus.i_rx = 1'b1;
      repeat (3) @(negedge clk);
      resetN = 1'b1;
      wait_ticks(20);
      check("midreset_no_dv", dv_cnt - n0, 0);
      $display("midreset: frame abandoned");
      send_frame(7'h41, 1'b1, 1'b1, st);
      check_frame("after_reset", 7'h41, 1'b0, 1'b0, st);

      // Back-to-back frames with no idle time.
      send_frame(7'h00, 1'b1, 1'b1, st0);
      check_frame("b2b_first", 7'h00, 1'b0, 1'b0, st0);
      send_frame(7'h41, 1'b1, 1'b1, st);
      check_frame("b2b_second", 7'h41, 1'b0, 1'b0, st);
      if (dv_cnt >= 2 && dv_cnt <= 64)
         check("b2b_spacing", cap_tick[dv_cnt - 1] - cap_tick[dv_cnt - 2], 10 * OS);
      bus.i_rx = 1'b1;
      wait_ticks(4);

      // Random frames against the frame-level model.
      for (int i = 0; i < 12; i++) begin
         rd = 7'($urandom_range(0, 127));
         rp = 1'($urandom_range(0, 1));
         rs = ($urandom_range(0, 3) != 0);
         exp_pe = ((($countones(rd) + int'(rp)) % 2) == 0);
         send_frame(rd, rp, rs, st);
         check_frame($sformatf("rand%0d", i), rd, exp_pe, !rs, st);
         bus.i_rx = 1'b1;
         wait_ticks(rs ? $urandom_range(0, 6) : $urandom_range(1, 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side counterpart of the team's UART transmitter.
- Frame format: start bit (0), 7 data bits LSB first, odd parity bit, stop bit (1).
- Samples the asynchronous serial line `rx` on oversampling ticks `rx_en` from the shared baud generator.
- Presents each received character on `data_out` with a one-cycle `data_valid` pulse and per-frame error flags.

Parameters:
- OVERSAMPLE, 16, `rx_en` ticks per bit period; even, minimum 4.
- DATA_BITS, 7, data bits per frame.

Ports:
- clk  input  1  system clock
- resetN  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, asynchronous to clk, idles high
- rx_en  input  1  one-clk-wide oversampling tick, OVERSAMPLE per bit period
- data_out  output  DATA_BITS  last received character
- data_valid  output  1  one-clk pulse, new character on data_out
- parity_error  output  1  parity mismatch in last frame
- framing_error  output  1  stop bit was 0 in last frame
- busy  output  1  frame reception in progress

Behaviour:
- Reset, asynchronous, resetN=0:
  - data_out=0, data_valid=0, parity_error=0, framing_error=0, busy=0.
  - State=IDLE; counters=0; synchroniser flops and rx_prev=1.
  - Reset asserted mid-frame abandons the frame immediately; no data_valid is produced for it.
- Synchronisation:
  - `rx` passes through a 2-flop synchroniser to give rx_s.
  - rx_prev holds rx_s as captured on the previous rx_en tick.
  - All FSM decisions are taken only on clk edges where rx_en=1.
- Tick counter: `tick` counts 0..OVERSAMPLE-1. "Sample" means acting on the rx_en tick where tick reaches its terminal value.
- IDLE:
  - busy=0.
  - On an rx_en tick with rx_prev=1 and rx_s=0 (falling edge): go to START, tick=0.
  - A line held low never re-triggers; a new high-to-low transition is required.
- START:
  - busy=1.
  - After OVERSAMPLE/2 ticks (mid start bit), sample rx_s.
  - rx_s=0: go to DATA, tick=0, bit=0.
  - rx_s=1: glitch; return to IDLE with no outputs changed.
- DATA:
  - Sample every OVERSAMPLE ticks, i.e. at the mid-point of each bit.
  - Shift rx_s into shift[bit], LSB first, then bit++.
  - After bit DATA_BITS-1 is sampled: go to PARITY, tick=0.
- PARITY: sample after OVERSAMPLE ticks into par; go to STOP, tick=0.
- STOP: sample after OVERSAMPLE ticks, then on the same clk edge:
  - data_out ← shift.
  - parity_error ← (par != ~^shift), i.e. odd parity over data plus parity bit.
  - framing_error ← ~rx_s.
  - data_valid=1.
  - Go to IDLE.
- data_valid timing:
  - High exactly one clk, on the cycle after the mid-stop-bit sampling tick.
  - Latency from start-bit falling edge: (DATA_BITS+2)·OVERSAMPLE + OVERSAMPLE/2 rx_en ticks, plus 2 clk of synchroniser delay.
  - A character with errors is still delivered, with data_valid=1.
- Output holding:
  - data_out, parity_error and framing_error hold until the next data_valid.
  - They are overwritten on every frame: error flags are not sticky across frames.
- Back-to-back frames: IDLE is entered at mid-stop-bit, so a start edge arriving immediately after the stop bit is detected with no lost frame.
- rx_en=0 continuously freezes the FSM and tick counter. The synchroniser keeps running.

Test Plan:
1. OVERSAMPLE=16. Frame data 0x55 (LSB first 1,0,1,0,1,0,1), parity 1, stop 1.
   - data_out=0x55, single-cycle data_valid, parity_error=0, framing_error=0.
   - busy falls at the same edge data_valid rises.
2. Data 0x7F sent with parity 1 (correct value is 0).
   - data_out=0x7F, parity_error=1, framing_error=0.
   - A following correct frame 0x00 (parity 1) clears parity_error to 0.
3. Data 0x2A, parity 0, stop bit 0, then line held low for 3 bit periods.
   - framing_error=1, data_out=0x2A.
   - No further busy or data_valid until rx returns high and falls again.
4. rx pulsed low for 4 rx_en ticks only.
   - busy=1 for 8 ticks, then 0.
   - No data_valid; outputs unchanged.
5. resetN pulsed low during data bit 3 of a frame.
   - All outputs 0 asynchronously, busy=0.
   - Next full frame 0x41 (parity 1) is received correctly: data_out=0x41, no errors.
6. Back-to-back frames 0x00 (parity 1) and 0x41 (parity 1) with zero idle time after the first stop bit.
   - Two data_valid pulses 10·OVERSAMPLE ticks apart, carrying 0x00 then 0x41, no errors.
